// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the adder arbiter slice.
// Imported by every file that needs the state encoding or default width.
package adder_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bus between the datapath clients and the shared-adder arbiter.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// a raised valid must hold, with stable payload, until it is matched by ready.
interface adder_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic [WIDTH-1:0]         resp_sum;
  logic                     resp_overflow;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sum, resp_overflow
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum, resp_overflow
  );
endinterface

// File: rtl/adder.sv
// The shared combinational adder: plain modulo-2^WIDTH sum, no carry-out.
module Adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum
);
  assign o_sum = i_a + i_b;
endmodule

// File: rtl/adder_rr_picker.sv
// Combinational round-robin picker: first set request at or after i_rr_ptr,
// wrapping modulo NUM_REQ. Outputs a one-hot grant plus its encoded index.
module adder_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);
  int w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = (int'(i_rr_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[w_pos]) begin
        o_any          = 1'b1;
        o_idx          = ID_W'(w_pos);
        o_grant[w_pos] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/adder_arbiter.sv
// Shares one Adder among NUM_REQ requesters: round-robin grant in IDLE, captured
// operands feed the adder, and the sum is held in RESP until the consumer takes it.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic            clk,
  input  logic            reset,
  adder_arbiter_if.slave  bus,
  output state_t          o_state,
  output logic [ID_W-1:0] o_rr_ptr
);
  state_t             r_state;
  state_t             w_state_nxt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [ID_W-1:0]    r_id;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic               w_accept;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [WIDTH-1:0]   w_sum;

  adder_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .i_req    (bus.req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  Adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a   (r_op_a),
    .i_b   (r_op_b),
    .o_sum (w_sum)
  );

  assign w_ptr_nxt = (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + ID_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The grant is offered whenever any request is up, so any request means accept.
        if (w_any && !reset) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_id     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op_a   <= bus.req_a[w_idx*WIDTH +: WIDTH];
        r_op_b   <= bus.req_b[w_idx*WIDTH +: WIDTH];
        r_id     <= w_idx;
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  assign bus.req_ready     = (r_state == S_IDLE && !reset) ? w_grant : '0;
  assign bus.resp_valid    = (r_state == S_RESP);
  assign bus.resp_id       = r_id;
  assign bus.resp_sum      = w_sum;
  // Signed overflow: like-signed operands producing a result of the other sign.
  assign bus.resp_overflow = (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != r_op_a[WIDTH-1]);

  assign o_state  = r_state;
  assign o_rr_ptr = r_rr_ptr;
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed vector table, hand-written multi-cycle sequences,
// and a randomized phase scored against a queue-based round-robin reference model.
module tb_adder_arbiter;
  import adder_arbiter_pkg::*;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int EW = 1 + IW + W;

  logic      clk;
  logic      reset;
  state_t    dbg_state;
  logic [IW-1:0] dbg_ptr;

  adder_arbiter_if #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW)) bus ();

  adder_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .o_state  (dbg_state),
    .o_rr_ptr (dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // ---------------- driver ----------------
  task automatic drive_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[id*W +: W] = a;
    bus.req_b[id*W +: W] = b;
    bus.req_valid[id]    = 1'b1;
  endtask

  // Single-requester transaction with consumer always ready.
  task automatic single_txn(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] e_sum, input logic e_ovf);
    logic [N-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    bus.resp_ready = 1'b1;
    drive_req(id, a, b);
    #1;
    chk("vec_req_ready", 64'(bus.req_ready), 64'(oh));
    tick();
    bus.req_valid = '0;
    #1;
    chk("vec_resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("vec_resp_id", 64'(bus.resp_id), 64'(id));
    chk("vec_resp_sum", 64'(bus.resp_sum), 64'(e_sum));
    chk("vec_resp_ovf", 64'(bus.resp_overflow), 64'(e_ovf));
    chk("vec_ready_in_resp", 64'(bus.req_ready), 64'd0);
    tick();
    chk("vec_back_idle", 64'(bus.resp_valid), 64'd0);
  endtask

  typedef struct {
    int         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic       ovf;
  } vec_t;

  vec_t vecs[7];

  // random-phase model state
  logic [N-1:0] pend;
  logic [W-1:0] pa[N];
  logic [W-1:0] pb[N];
  logic [W-1:0] corners[6];
  int           mptr;
  bit           mbusy;

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;

    vecs[0] = '{2, 32'd1,          32'd2,          32'd3,          1'b0};
    vecs[1] = '{0, 32'h7FFF_FFFF,  32'd2,          32'h8000_0001,  1'b1};
    vecs[2] = '{1, 32'h7FFF_FFFF,  32'h8000_0001,  32'd0,          1'b0};
    vecs[3] = '{3, 32'hFFFE_7960,  32'h0001_86A0,  32'd0,          1'b0};
    vecs[4] = '{2, 32'h8000_0000,  32'h8000_0000,  32'd0,          1'b1};
    vecs[5] = '{1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h7FFF_FFFF,  1'b1};
    vecs[6] = '{0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};

    // Reset with a request pending: ready must stay low while reset is high.
    drive_req(1, 32'd5, 32'd6);
    tick();
    #1;
    chk("ready_in_reset", 64'(bus.req_ready), 64'd0);
    tick();
    bus.req_valid = '0;
    reset = 1'b0;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_sum", 64'(bus.resp_sum), 64'd0);
    chk("rst_resp_id", 64'(bus.resp_id), 64'd0);
    chk("rst_resp_ovf", 64'(bus.resp_overflow), 64'd0);
    chk("rst_rr_ptr", 64'(dbg_ptr), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
    tick();
    tick();
    chk("idle_stays", 64'(bus.resp_valid), 64'd0);
    chk("idle_ptr", 64'(dbg_ptr), 64'd0);

    // ---------- table-driven vectors ----------
    for (int v = 0; v < 7; v++)
      single_txn(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sum, vecs[v].ovf);

    // ---------- round robin with all four held valid ----------
    do_reset();
    for (int i = 0; i < N; i++) drive_req(i, 32'(100 * (i + 1)), 32'(i + 7));
    for (int n = 0; n < 5; n++) begin
      logic [N-1:0] oh;
      oh = '0;
      oh[n % N] = 1'b1;
      #1;
      chk("rr_grant", 64'(bus.req_ready), 64'(oh));
      tick();
      chk("rr_resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("rr_resp_id", 64'(bus.resp_id), 64'(n % N));
      chk("rr_resp_sum", 64'(bus.resp_sum), 64'(100 * ((n % N) + 1) + (n % N) + 7));
      chk("rr_no_grant_in_resp", 64'(bus.req_ready), 64'd0);
      tick();
    end
    bus.req_valid = '0;
    do_reset();

    // ---------- backpressure ----------
    bus.resp_ready = 1'b0;
    drive_req(1, 32'd0, 32'hFFFF_FFFF);
    tick();
    bus.req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_valid", 64'(bus.resp_valid), 64'd1);
      chk("bp_sum", 64'(bus.resp_sum), 64'hFFFF_FFFF);
      chk("bp_id", 64'(bus.resp_id), 64'd1);
      chk("bp_ovf", 64'(bus.resp_overflow), 64'd0);
      chk("bp_ready", 64'(bus.req_ready), 64'd0);
      tick();
    end
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    tick();
    chk("bp_release_idle", 64'(dbg_state), 64'(S_IDLE));
    chk("bp_release_valid", 64'(bus.resp_valid), 64'd0);

    // ---------- reset mid-operation ----------
    bus.resp_ready = 1'b0;
    drive_req(2, 32'd9, 32'd9);
    tick();
    bus.req_valid = '0;
    chk("mid_in_resp", 64'(bus.resp_valid), 64'd1);
    chk("mid_ptr_moved", 64'(dbg_ptr), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    chk("mid_resp_dropped", 64'(bus.resp_valid), 64'd0);
    chk("mid_ptr_zero", 64'(dbg_ptr), 64'd0);
    single_txn(3, 32'd40, 32'd2, 32'd42, 1'b0);
    drive_req(0, 32'd1, 32'd1);
    drive_req(3, 32'd3, 32'd3);
    #1;
    chk("mid_two_grant0", 64'(bus.req_ready), 64'b0001);
    tick();
    bus.req_valid[0] = 1'b0;
    chk("mid_two_sum0", 64'(bus.resp_sum), 64'd2);
    tick();
    #1;
    chk("mid_two_grant3", 64'(bus.req_ready), 64'b1000);
    tick();
    bus.req_valid = '0;
    chk("mid_two_sum3", 64'(bus.resp_sum), 64'd6);
    tick();

    // ---------- randomized phase against reference model ----------
    do_reset();
    corners[0] = 32'h7FFF_FFFF;
    corners[1] = 32'h8000_0000;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h0000_0000;
    corners[4] = 32'h0000_0001;
    corners[5] = 32'h8000_0001;
    pend  = '0;
    mptr  = 0;
    mbusy = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      int g;
      logic [N-1:0] exp_rdy;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i] = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
          pb[i] = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
        end
        if (pend[i]) drive_req(i, pa[i], pb[i]);
        else bus.req_valid[i] = 1'b0;
      end
      bus.resp_ready = ($urandom_range(0, 2) != 0);
      // Model grant: first pending requester at or after the pointer, wrapping.
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && pend[(mptr + k) % N]) g = (mptr + k) % N;
      exp_rdy = '0;
      if (!mbusy && g >= 0) exp_rdy[g] = 1'b1;
      #1;
      chk("rnd_req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      chk("rnd_resp_valid", 64'(bus.resp_valid), 64'(mbusy));
      if (mbusy && exp_q.size() > 0)
        chk("rnd_resp", 64'({bus.resp_overflow, bus.resp_id, bus.resp_sum}), 64'(exp_q[0]));
      tick();
      if (!mbusy && g >= 0) begin
        exp_q.push_back({ref_ovf(pa[g], pb[g]), IW'(g), pa[g] + pb[g]});
        mptr    = (g + 1) % N;
        pend[g] = 1'b0;
        mbusy   = 1;
      end else if (mbusy && bus.resp_ready) begin
        void'(exp_q.pop_front());
        mbusy = 0;
      end
    end
    bus.req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
